vnu_serial: RTL and testbench

VNU_SERIAL -- requirements
Module: vnu_serial

---
 rtl/vnu_serial.sv | 259 +++++++++++++++++++++++++
 tb/tb_vnu_serial.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vnu_serial.sv
`default_nettype none
// ============================================================================
// Module   : vnu_serial
// Purpose  : Serial variable-node unit for a layered/flooding LDPC decoder.
//            Z lanes run in lock-step.  A column is processed in three phases:
//              IDLE  : wait for start, latch degree and channel LLRs
//              ACCUM : accept deg C2V beats, buffer each one and accumulate
//                      the total (LLR + all C2V)
//              EMIT  : stream deg V2C beats, V2C[k] = sat(total - C2V[k])
//            The hard decision is the sign of the total, refreshed on EMIT
//            entry (or immediately for a degree-0 column).
// Ports    : clk, rst (async, active-high)
//            start, llr_in[Z][BITS], deg         - column launch
//            c2v_valid/c2v_ready, c2v_in[Z][BITS] - C2V input stream
//            v2c_valid/v2c_ready, v2c_out[Z][BITS], v2c_idx - V2C stream
//            hard[Z], busy, done                  - status
//            sat_cnt[16] (only with VNU_SAT_STATS_EN) - clipped-beat count
// Options  : `define VNU_SAT_STATS_EN to add the saturation statistic.
// Revision : 1.0 - initial release
// ============================================================================
module vnu_serial #(
  parameter int BITS = 8,
  parameter int Z    = 32,
  parameter int DMAX = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [Z-1:0][BITS-1:0]         llr_in,
  input  logic [$clog2(DMAX+1)-1:0]      deg,
  input  logic                           c2v_valid,
  output logic                           c2v_ready,
  input  logic [Z-1:0][BITS-1:0]         c2v_in,
  output logic                           v2c_valid,
  input  logic                           v2c_ready,
  output logic [Z-1:0][BITS-1:0]         v2c_out,
  output logic [$clog2(DMAX)-1:0]        v2c_idx,
  output logic [Z-1:0]                   hard,
  output logic                           busy,
  output logic                           done
`ifdef VNU_SAT_STATS_EN
  ,
  output logic [15:0]                    sat_cnt
`endif
);

  localparam int DW = $clog2(DMAX+1);   // degree width
  localparam int KW = $clog2(DMAX);     // edge-index width
  // Total of LLR plus up to DMAX messages fits with DW guard bits.
  localparam int AW = BITS + DW;

  localparam logic [DW-1:0]        c_dmax = DW'(DMAX);
  localparam logic signed [AW-1:0] c_pos  = AW'(2**(BITS-1) - 1);
  localparam logic signed [AW-1:0] c_neg  = -c_pos;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0]           r_deg;
  logic [KW-1:0]           r_k;
  logic [AW-1:0]           r_sum [Z];
  logic [Z-1:0][BITS-1:0]  r_buf [DMAX];
  logic [Z-1:0]            r_hard;
  logic                    r_done;

  logic [DW-1:0]           w_deg_cl;
  logic                    w_last;
  logic                    w_accept;
  logic                    w_done_set;
  logic [AW-1:0]           w_llr_ext [Z];
  logic [AW-1:0]           w_sum_add [Z];
  logic [Z-1:0][BITS-1:0]  w_sat;
`ifdef VNU_SAT_STATS_EN
  logic [Z-1:0]            w_clip;
`endif

  // Oversized degrees are treated as a full-degree column.
  assign w_deg_cl = (deg > c_dmax) ? c_dmax : deg;
  assign w_last   = (DW'(r_k) == (r_deg - DW'(1)));

  // --------------------------------------------------------------------------
  // Per-lane arithmetic: LLR sign extension, running accumulation and the
  // extrinsic (total minus own message) with symmetric saturation.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < Z; l++) begin : g_lane
    logic [AW-1:0] w_c2v_ext;
    logic [AW-1:0] w_buf_ext;
    logic [AW-1:0] w_diff;
    logic          w_hi;
    logic          w_lo;

    assign w_llr_ext[l] = {{DW{llr_in[l][BITS-1]}}, llr_in[l]};
    assign w_c2v_ext    = {{DW{c2v_in[l][BITS-1]}}, c2v_in[l]};
    assign w_sum_add[l] = r_sum[l] + w_c2v_ext;

    assign w_buf_ext = {{DW{r_buf[r_k][l][BITS-1]}}, r_buf[r_k][l]};
    assign w_diff    = r_sum[l] - w_buf_ext;
    assign w_hi      = ($signed(w_diff) > c_pos);
    // Clamping at -(2^(BITS-1)-1) keeps the message range symmetric, so the
    // most-negative code is never produced.
    assign w_lo      = ($signed(w_diff) < c_neg);
    assign w_sat[l]  = w_hi ? c_pos[BITS-1:0] :
                       w_lo ? c_neg[BITS-1:0] : w_diff[BITS-1:0];

    // Output is forced to zero outside EMIT so stale buffer data never leaks.
    assign v2c_out[l] = (r_state == EMIT) ? w_sat[l] : '0;
`ifdef VNU_SAT_STATS_EN
    assign w_clip[l]  = w_hi | w_lo;
`endif
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    c2v_ready  = 1'b0;
    v2c_valid  = 1'b0;
    w_accept   = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_deg_cl != '0) begin
            w_next = ACCUM;
          end else begin
            // Degree 0: nothing to exchange, finish immediately.
            w_done_set = 1'b1;
          end
        end
      end
      ACCUM: begin
        c2v_ready = 1'b1;
        if (c2v_valid && w_last) begin
          w_next = EMIT;
        end
      end
      EMIT: begin
        v2c_valid = 1'b1;
        if (v2c_ready && w_last) begin
          w_next     = IDLE;
          w_done_set = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: degree, edge counter, accumulators, hard decision, done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deg  <= '0;
      r_k    <= '0;
      r_hard <= '0;
      r_done <= 1'b0;
      for (int l = 0; l < Z; l++) begin
        r_sum[l] <= '0;
      end
    end else begin
      r_done <= w_done_set;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_deg <= w_deg_cl;
            r_k   <= '0;
            for (int l = 0; l < Z; l++) begin
              r_sum[l] <= w_llr_ext[l];
            end
            if (w_deg_cl == '0) begin
              for (int l = 0; l < Z; l++) begin
                r_hard[l] <= llr_in[l][BITS-1];
              end
            end
          end
        end
        ACCUM: begin
          if (c2v_valid) begin
            for (int l = 0; l < Z; l++) begin
              r_sum[l] <= w_sum_add[l];
            end
            if (w_last) begin
              // Total is complete on this beat: rewind for EMIT and take
              // the hard decision from the final sum.
              r_k <= '0;
              for (int l = 0; l < Z; l++) begin
                r_hard[l] <= w_sum_add[l][AW-1];
              end
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        EMIT: begin
          // Counter holds on the last beat; leaving EMIT is handled by the FSM.
          if (v2c_ready && !w_last) begin
            r_k <= r_k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Message buffer: no reset needed, every entry read is written first.
  always_ff @(posedge clk) begin
    if ((r_state == ACCUM) && c2v_valid) begin
      r_buf[r_k] <= c2v_in;
    end
  end

  assign v2c_idx = (r_state == EMIT) ? r_k : '0;
  assign hard    = r_hard;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;

`ifdef VNU_SAT_STATS_EN
  // --------------------------------------------------------------------------
  // Saturation statistic: V2C beats where at least one lane clipped.
  // --------------------------------------------------------------------------
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (w_accept) begin
      r_sat_cnt <= '0;
    end else if (v2c_valid && v2c_ready && (|w_clip) && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vnu_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_vnu_serial
// Purpose  : Self-checking bench for vnu_serial (BITS=8, Z=4, DMAX=10).
//            Table of column vectors with hand-computed V2C results plus
//            directed sequences for stall, mid-column reset and degree clamp.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vnu_serial;

  localparam int BITS = 8;
  localparam int Z    = 4;
  localparam int DMAX = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [Z-1:0][BITS-1:0] llr_in = '0;
  logic [3:0]             deg = '0;
  logic                   c2v_valid = 1'b0;
  logic                   c2v_ready;
  logic [Z-1:0][BITS-1:0] c2v_in = '0;
  logic                   v2c_valid;
  logic                   v2c_ready = 1'b0;
  logic [Z-1:0][BITS-1:0] v2c_out;
  logic [3:0]             v2c_idx;
  logic [Z-1:0]           hard;
  logic                   busy;
  logic                   done;
`ifdef VNU_SAT_STATS_EN
  logic [15:0]            sat_cnt;
`endif

  int    n_total = 0;
  int    n_bad   = 0;
  string tag     = "reset";

  vnu_serial #(.BITS(BITS), .Z(Z), .DMAX(DMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .llr_in    (llr_in),
    .deg       (deg),
    .c2v_valid (c2v_valid),
    .c2v_ready (c2v_ready),
    .c2v_in    (c2v_in),
    .v2c_valid (v2c_valid),
    .v2c_ready (v2c_ready),
    .v2c_out   (v2c_out),
    .v2c_idx   (v2c_idx),
    .hard      (hard),
    .busy      (busy),
    .done      (done)
`ifdef VNU_SAT_STATS_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [3:0][7:0]       llr;        // per lane, lane 0 in [0]
    logic [3:0]            deg;
    logic [3:0][7:0]       c2v;        // beat b value, broadcast to all lanes
    logic [3:0][3:0][7:0]  exp_v2c;    // [beat][lane]
    logic [3:0]            exp_hard;
    logic [7:0]            exp_clips;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [3:0][7:0] l4(input int a, input int b, input int c, input int d);
    l4 = {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [3:0][7:0] bc(input int a);
    bc = l4(a, a, a, a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge; launches the column right there and returns at
  // the falling edge where done is expected high.
  task automatic run_vec(input int vi);
    vec_t v;
    v = vecs[vi];
    start  = 1'b1;
    llr_in = v.llr;
    deg    = v.deg;
    @(negedge clk);
    start = 1'b0;
    if (v.deg == 4'd0) begin
      chk("zero_done",  64'(done),      64'd1);
      chk("zero_ready", 64'(c2v_ready), 64'd0);
      chk("zero_valid", 64'(v2c_valid), 64'd0);
      chk("zero_busy",  64'(busy),      64'd0);
      chk("zero_hard",  64'(hard),      64'(v.exp_hard));
    end else begin
      chk("acc_done_low", 64'(done), 64'd0);
      for (int b = 0; b < int'(v.deg); b++) begin
        chk("c2v_ready", 64'(c2v_ready), 64'd1);
        chk("v2c_valid_low", 64'(v2c_valid), 64'd0);
        c2v_valid = 1'b1;
        c2v_in    = bc(int'($signed(v.c2v[b])));
        @(negedge clk);
      end
      c2v_valid = 1'b0;
      v2c_ready = 1'b1;
      for (int b = 0; b < int'(v.deg); b++) begin
        chk("v2c_valid", 64'(v2c_valid), 64'd1);
        chk("c2v_ready_low", 64'(c2v_ready), 64'd0);
        chk("v2c_idx",   64'(v2c_idx),   64'(b));
        chk("v2c_out",   64'(v2c_out),   64'(v.exp_v2c[b]));
        if (b == 0) chk("hard", 64'(hard), 64'(v.exp_hard));
        @(negedge clk);
      end
      v2c_ready = 1'b0;
      chk("end_done",  64'(done),      64'd1);
      chk("end_busy",  64'(busy),      64'd0);
      chk("end_valid", 64'(v2c_valid), 64'd0);
    end
`ifdef VNU_SAT_STATS_EN
    chk("sat_cnt", 64'(sat_cnt), 64'(v.exp_clips));
`endif
  endtask

  initial begin
    // ---------------- vector table ----------------
    vecs[0] = '0;   // llr 5, C2V 1,2,3 -> total 11
    vecs[0].llr = bc(5);  vecs[0].deg = 4'd3;  vecs[0].c2v = l4(1, 2, 3, 0);
    vecs[0].exp_v2c[0] = bc(10); vecs[0].exp_v2c[1] = bc(9); vecs[0].exp_v2c[2] = bc(8);
    vecs[0].exp_hard = 4'b0000; vecs[0].exp_clips = 8'd0;

    vecs[1] = '0;   // llr -100, C2V -100,-100 -> total -300, extrinsic -200 clips
    vecs[1].llr = bc(-100); vecs[1].deg = 4'd2; vecs[1].c2v = l4(-100, -100, 0, 0);
    vecs[1].exp_v2c[0] = bc(-127); vecs[1].exp_v2c[1] = bc(-127);
    vecs[1].exp_hard = 4'b1111; vecs[1].exp_clips = 8'd2;

    vecs[2] = '0;   // per-lane llr, one C2V 20: extrinsic = llr, -128 clamps to -127
    vecs[2].llr = l4(10, -10, 127, -128); vecs[2].deg = 4'd1; vecs[2].c2v = l4(20, 0, 0, 0);
    vecs[2].exp_v2c[0] = l4(10, -10, 127, -127);
    vecs[2].exp_hard = 4'b1000; vecs[2].exp_clips = 8'd1;

    vecs[3] = '0;   // C2V 30,-40,100,-128 sum -38; totals -38,-37,-39,12
    vecs[3].llr = l4(0, 1, -1, 50); vecs[3].deg = 4'd4; vecs[3].c2v = l4(30, -40, 100, -128);
    vecs[3].exp_v2c[0] = l4(-68, -67, -69, -18);
    vecs[3].exp_v2c[1] = l4(2, 3, 1, 52);
    vecs[3].exp_v2c[2] = l4(-127, -127, -127, -88);
    vecs[3].exp_v2c[3] = l4(90, 91, 89, 127);
    vecs[3].exp_hard = 4'b0111; vecs[3].exp_clips = 8'd2;

    vecs[4] = '0;   // degree 0: hard = sign(llr)
    vecs[4].llr = l4(-1, 0, 5, -128); vecs[4].deg = 4'd0;
    vecs[4].exp_hard = 4'b1001; vecs[4].exp_clips = 8'd0;

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    chk("rst_c2v_ready", 64'(c2v_ready), 64'd0);
    chk("rst_v2c_valid", 64'(v2c_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_hard",      64'(hard),      64'd0);
    chk("rst_v2c_out",   64'(v2c_out),   64'd0);
    chk("rst_v2c_idx",   64'(v2c_idx),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);

    // ---------------- stall during idx 1 ----------------
    tag = "stall";
    start = 1'b1; llr_in = bc(0); deg = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      c2v_valid = 1'b1;
      c2v_in    = bc(b + 1);       // total 10
      @(negedge clk);
    end
    c2v_valid = 1'b0;
    v2c_ready = 1'b1;
    chk("idx0",  64'(v2c_idx), 64'd0);
    chk("out0",  64'(v2c_out), 64'(bc(9)));
    chk("hard",  64'(hard),    64'd0);
    @(negedge clk);
    v2c_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", 64'(v2c_valid), 64'd1);
      chk("stall_idx",   64'(v2c_idx),   64'd1);
      chk("stall_out",   64'(v2c_out),   64'(bc(8)));
      @(negedge clk);
    end
    v2c_ready = 1'b1;
    chk("idx1", 64'(v2c_idx), 64'd1);
    chk("out1", 64'(v2c_out), 64'(bc(8)));
    @(negedge clk);
    chk("idx2", 64'(v2c_idx), 64'd2);
    chk("out2", 64'(v2c_out), 64'(bc(7)));
    @(negedge clk);
    chk("idx3", 64'(v2c_idx), 64'd3);
    chk("out3", 64'(v2c_out), 64'(bc(6)));
    @(negedge clk);
    v2c_ready = 1'b0;
    chk("done", 64'(done), 64'd1);

    // ---------------- table (first start lands while done is high) ----------
    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(i);
    end

    // ---------------- reset mid-column ----------------
    tag = "rst_mid";
    chk("hard_before", 64'(hard), 64'b1001);
    start = 1'b1; llr_in = bc(-3); deg = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      c2v_valid = 1'b1;
      c2v_in    = bc(9);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("c2v_ready", 64'(c2v_ready), 64'd0);
    chk("busy",      64'(busy),      64'd0);
    chk("hard",      64'(hard),      64'd0);
    chk("v2c_valid", 64'(v2c_valid), 64'd0);
    chk("done",      64'(done),      64'd0);
    c2v_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_done", 64'(done), 64'd0);
    start = 1'b1; llr_in = bc(3); deg = 4'd1;
    @(negedge clk);
    start = 1'b0;
    c2v_valid = 1'b1; c2v_in = bc(7);
    @(negedge clk);
    c2v_valid = 1'b0; v2c_ready = 1'b1;
    chk("new_valid", 64'(v2c_valid), 64'd1);
    chk("new_out",   64'(v2c_out),   64'(bc(3)));
    chk("new_hard",  64'(hard),      64'd0);
    @(negedge clk);
    v2c_ready = 1'b0;
    chk("new_done",  64'(done), 64'd1);

    // ---------------- degree clamp, start ignored while busy ----------------
    tag = "clamp";
    start = 1'b1; llr_in = bc(0); deg = 4'd15;
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      chk("c2v_ready", 64'(c2v_ready), 64'd1);
      c2v_valid = 1'b1;
      c2v_in    = bc(1);          // total 10
      start     = (b == 3);
      deg       = (b == 3) ? 4'd1 : 4'd15;
      llr_in    = (b == 3) ? bc(-50) : bc(0);
      @(negedge clk);
    end
    start = 1'b0;                 // c2v_valid left high: an 11th beat is offered
    chk("c2v_ready_11", 64'(c2v_ready), 64'd0);
    chk("v2c_valid",    64'(v2c_valid), 64'd1);
    v2c_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      chk("v2c_idx", 64'(v2c_idx), 64'(b));
      chk("v2c_out", 64'(v2c_out), 64'(bc(9)));
      start = (b == 4);
      @(negedge clk);
    end
    start = 1'b0; c2v_valid = 1'b0; v2c_ready = 1'b0;
    chk("done", 64'(done), 64'd1);
    chk("busy", 64'(busy), 64'd0);
    chk("hard", 64'(hard), 64'd0);
`ifdef VNU_SAT_STATS_EN
    chk("sat_cnt", 64'(sat_cnt), 64'd0);
`endif
    @(negedge clk);
    chk("done_pulse_end", 64'(done), 64'd0);
    chk("idle_after",     64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
